vga_console_scanner: RTL

Parametrised successor to the console sync counter: converts the visible-pixel stream of the VGA sync generator into text-cell and glyph-pixel coordinates for a character console. It adds integer pixel replication (HSCALE/VSCALE), a text-area flag for displays larger than the console, a multiplier-free character-RAM address, and a one-cycle fetch strobe per glyph cell. It sits between the sync generator and the character RAM / glyph ROM pipeline, in the `pixel_clk` domain.

---
 rtl/vga_console_scanner.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/vga_console_scanner.sv
// Maps the visible-pixel stream onto text-cell / glyph-pixel coordinates,
// with pixel replication, console-area flag, char-RAM address and fetch strobe.
module vga_console_scanner #(
    parameter int TEXT_COLUMNS  = 80,
    parameter int TEXT_ROWS     = 30,
    parameter int GLYPH_COLUMNS = 8,
    parameter int GLYPH_ROWS    = 16,
    parameter int HSCALE        = 1,
    parameter int VSCALE        = 1,
    parameter int ADDR_WIDTH    = 12,
    localparam int CW  = (TEXT_COLUMNS > 1) ? $clog2(TEXT_COLUMNS) : 1,
    localparam int RW  = (TEXT_ROWS > 1) ? $clog2(TEXT_ROWS) : 1,
    localparam int GXW = (GLYPH_COLUMNS > 1) ? $clog2(GLYPH_COLUMNS) : 1,
    localparam int GYW = (GLYPH_ROWS > 1) ? $clog2(GLYPH_ROWS) : 1
) (
    input  logic                  pixel_clk,
    input  logic                  reset,
    input  logic                  frame_start,
    input  logic                  line_start,
    input  logic                  pixel_visible,
    output logic [CW-1:0]         text_col,
    output logic [RW-1:0]         text_row,
    output logic [GXW-1:0]        glyph_x,
    output logic [GYW-1:0]        glyph_y,
    output logic [ADDR_WIDTH-1:0] char_addr,
    output logic                  text_active,
    output logic                  char_fetch
);

    localparam logic [1:0]            HMAX   = 2'(HSCALE - 1);
    localparam logic [1:0]            VMAX   = 2'(VSCALE - 1);
    localparam logic [GXW-1:0]        GXMAX  = GXW'(GLYPH_COLUMNS - 1);
    localparam logic [GYW-1:0]        GYMAX  = GYW'(GLYPH_ROWS - 1);
    localparam logic [CW-1:0]         COLMAX = CW'(TEXT_COLUMNS - 1);
    localparam logic [RW-1:0]         ROWMAX = RW'(TEXT_ROWS - 1);
    localparam logic [ADDR_WIDTH-1:0] STEP   = ADDR_WIDTH'(TEXT_COLUMNS);

    logic [1:0]            hph_q, hph_d;
    logic [GXW-1:0]        gx_q, gx_d;
    logic [CW-1:0]         col_q, col_d;
    logic                  h_in_q, h_in_d;
    logic [1:0]            vph_q, vph_d;
    logic [GYW-1:0]        gy_q, gy_d;
    logic [RW-1:0]         row_q, row_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d;
    logic                  v_in_q, v_in_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  act_q, act_d;
    logic                  fetch_q, fetch_d;
    logic                  new_cell;

    always_comb begin
        hph_d    = hph_q;
        gx_d     = gx_q;
        col_d    = col_q;
        h_in_d   = h_in_q;
        vph_d    = vph_q;
        gy_d     = gy_q;
        row_d    = row_q;
        base_d   = base_q;
        v_in_d   = v_in_q;
        new_cell = 1'b0;

        if (frame_start) begin
            vph_d  = '0;
            gy_d   = '0;
            row_d  = '0;
            base_d = '0;
            v_in_d = 1'b1;
        end else if (line_start && v_in_q) begin
            if (vph_q == VMAX) begin
                vph_d = '0;
                if (gy_q == GYMAX) begin
                    gy_d = '0;
                    if (row_q == ROWMAX) begin
                        row_d  = '0;
                        base_d = '0;
                        v_in_d = 1'b0;
                    end else begin
                        row_d  = row_q + RW'(1);
                        base_d = base_q + STEP;
                    end
                end else begin
                    gy_d = gy_q + GYW'(1);
                end
            end else begin
                vph_d = vph_q + 2'd1;
            end
        end

        // Lines outside the console rows never enter the horizontal area.
        if (frame_start || line_start) begin
            hph_d    = '0;
            gx_d     = '0;
            col_d    = '0;
            h_in_d   = v_in_d;
            new_cell = v_in_d;
        end else if (pixel_visible && h_in_q) begin
            if (hph_q == HMAX) begin
                hph_d = '0;
                if (gx_q == GXMAX) begin
                    gx_d = '0;
                    if (col_q == COLMAX) begin
                        col_d  = '0;
                        h_in_d = 1'b0;
                    end else begin
                        col_d    = col_q + CW'(1);
                        new_cell = 1'b1;
                    end
                end else begin
                    gx_d = gx_q + GXW'(1);
                end
            end else begin
                hph_d = hph_q + 2'd1;
            end
        end

        act_d   = h_in_d & v_in_d;
        addr_d  = act_d ? base_d + ADDR_WIDTH'(col_d) : '0;
        fetch_d = act_d & new_cell;
    end

    always_ff @(posedge pixel_clk or posedge reset) begin
        if (reset) begin
            hph_q   <= '0;
            gx_q    <= '0;
            col_q   <= '0;
            h_in_q  <= 1'b0;
            vph_q   <= '0;
            gy_q    <= '0;
            row_q   <= '0;
            base_q  <= '0;
            v_in_q  <= 1'b0;
            addr_q  <= '0;
            act_q   <= 1'b0;
            fetch_q <= 1'b0;
        end else begin
            hph_q   <= hph_d;
            gx_q    <= gx_d;
            col_q   <= col_d;
            h_in_q  <= h_in_d;
            vph_q   <= vph_d;
            gy_q    <= gy_d;
            row_q   <= row_d;
            base_q  <= base_d;
            v_in_q  <= v_in_d;
            addr_q  <= addr_d;
            act_q   <= act_d;
            fetch_q <= fetch_d;
        end
    end

    assign text_col    = col_q;
    assign text_row    = row_q;
    assign glyph_x     = gx_q;
    assign glyph_y     = gy_q;
    assign char_addr   = addr_q;
    assign text_active = act_q;
    assign char_fetch  = fetch_q;

endmodule
